// File: rtl/array_sort_check_pkg.sv
// Shared definitions for the array sort-check controller and its datapath.
//   INDEX_W : width of the element index (and of the inv_index report)
//   state_t : controller FSM state, 3-bit encoding
package array_sort_check_pkg;

    localparam int unsigned INDEX_W = 5;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE          = 3'd0,
        ST_LOAD          = 3'd1,
        ST_CHECK         = 3'd2,
        ST_DONE_SORTED   = 3'd3,
        ST_DONE_UNSORTED = 3'd4
    } state_t;

endpackage

// File: rtl/array_sort_check_ctrl.sv
// Controller that walks an external array datapath and reports whether the
// array is sorted in non-decreasing order.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   go                level start request held by the requester
//   inversion_found   datapath: element[index] > element[index+1]
//   end_of_array      datapath: index >= length-1, or length == 0
//   load_input        datapath: capture array base and length
//   load_index        datapath: write index register
//   select_index      datapath: 0 = clear index, 1 = increment index
//   busy              check in progress
//   done              result valid
//   sorted            1 = no inversion found (valid while done = 1)
//   inv_index         index of the first inversion
//
// Build option: define ARRAY_SORT_CHECK_INV_INDEX_EN to track inv_index;
// otherwise inv_index is tied to 0.
//
// All strobes and status outputs are decoded from the state register, so the
// asynchronous reset clears them immediately.
module array_sort_check_ctrl
    import array_sort_check_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               inversion_found,
    input  logic               end_of_array,
    output logic               load_input,
    output logic               load_index,
    output logic               select_index,
    output logic               busy,
    output logic               done,
    output logic               sorted,
    output logic [INDEX_W-1:0] inv_index
);

    state_t state;
    state_t state_next;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next   = state;
        load_input   = 1'b0;
        load_index   = 1'b0;
        select_index = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        sorted       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                load_input   = 1'b1;
                load_index   = 1'b1;
                select_index = 1'b0;
                busy         = 1'b1;
                state_next   = ST_CHECK;
            end

            ST_CHECK: begin
                busy = 1'b1;
                // End of array wins: the pair beyond the last element is invalid.
                if (end_of_array) begin
                    state_next = ST_DONE_SORTED;
                end else if (inversion_found) begin
                    state_next = ST_DONE_UNSORTED;
                end else begin
                    load_index   = 1'b1;
                    select_index = 1'b1;
                end
            end

            ST_DONE_SORTED: begin
                done   = 1'b1;
                sorted = 1'b1;
                if (!go) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DONE_UNSORTED: begin
                done = 1'b1;
                if (!go) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef ARRAY_SORT_CHECK_INV_INDEX_EN
    logic [INDEX_W-1:0] inv_cnt;

    // Shadow of the datapath index; frozen once a result is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_cnt <= '0;
        end else if (state == ST_LOAD) begin
            inv_cnt <= '0;
        end else if (load_index && select_index) begin
            inv_cnt <= inv_cnt + INDEX_W'(1);
        end
    end

    assign inv_index = inv_cnt;
`else
    assign inv_index = '0;
`endif

endmodule

// File: tb/tb_array_sort_check_ctrl.sv
// Bench for array_sort_check_ctrl: pairs the controller with a behavioural
// array datapath and compares results, latency and strobe counts against
// expectations from a table and from a reference model.
module tb_array_sort_check_ctrl;

    localparam int unsigned TIMEOUT_EDGES = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       inversion_found;
    logic       end_of_array;
    logic       load_input;
    logic       load_index;
    logic       select_index;
    logic       busy;
    logic       done;
    logic       sorted;
    logic [4:0] inv_index;

    int n_checks = 0;
    int n_pass   = 0;

    // Datapath model: memory, captured base/length, index register
    logic [7:0] mem [64];
    logic [5:0] cfg_base;
    logic [5:0] cfg_len;
    logic [5:0] dp_base;
    logic [5:0] dp_len;
    logic [5:0] dp_idx;

    int vals [32];

    typedef struct {
        int vals [8];
        int base;
        int len;
        int exp_sorted;
        int exp_edge;
        int exp_strobes;
    } vec_t;

    vec_t tbl [8];

    array_sort_check_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .go              (go),
        .inversion_found (inversion_found),
        .end_of_array    (end_of_array),
        .load_input      (load_input),
        .load_index      (load_index),
        .select_index    (select_index),
        .busy            (busy),
        .done            (done),
        .sorted          (sorted),
        .inv_index       (inv_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_input) begin
            dp_base <= cfg_base;
            dp_len  <= cfg_len;
        end
        if (load_index) begin
            dp_idx <= select_index ? dp_idx + 6'd1 : 6'd0;
        end
    end

    assign end_of_array    = (dp_len == 6'd0) || (dp_idx >= dp_len - 6'd1);
    assign inversion_found = mem[6'(dp_base + dp_idx)] > mem[6'(dp_base + dp_idx + 6'd1)];

    task automatic check(input string tag, input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got %0d, expected %0d", tag, name, act, exp);
        end
    endtask

    // Reference model: scan for the first adjacent inversion
    task automatic model(input int len, output int exp_sorted, output int exp_edge,
                         output int exp_strobes);
        int k;
        k = -1;
        for (int i = 0; i + 1 < len; i++) begin
            if (k < 0 && vals[i] > vals[i+1]) k = i;
        end
        if (k >= 0) begin
            exp_sorted  = 0;
            exp_edge    = 3 + k;
            exp_strobes = k;
        end else begin
            exp_sorted  = 1;
            exp_edge    = (len <= 1) ? 3 : 2 + len;
            exp_strobes = (len <= 1) ? 0 : len - 1;
        end
    endtask

    // Called just after a falling edge; raises go and follows one full check.
    task automatic run_case(input string tag, input int base, input int len,
                            input int exp_sorted, input int exp_edge,
                            input int exp_strobes, input int hold_cycles);
        int edges, strobes, loads, done_edge, bad_busy, bad_hold, exp_inv;
        for (int i = 0; i < len; i++) mem[base + i] = 8'(vals[i]);
        // Element just beyond the end forms an inversion with the last one
        mem[base + len] = 8'd0;
        cfg_base  = 6'(base);
        cfg_len   = 6'(len);
        go        = 1'b1;
        edges     = 0;
        strobes   = 0;
        loads     = 0;
        done_edge = 0;
        bad_busy  = 0;
        while (edges < TIMEOUT_EDGES && done_edge == 0) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1 && hold_cycles == 0) go = 1'b0;
            if (load_input) loads++;
            if (load_index && select_index) strobes++;
            if (done) done_edge = edges;
            else if (!busy) bad_busy++;
        end
`ifdef ARRAY_SORT_CHECK_INV_INDEX_EN
        exp_inv = exp_strobes;
`else
        exp_inv = 0;
`endif
        check(tag, "done_edge", done_edge, exp_edge);
        check(tag, "sorted", int'(sorted), exp_sorted);
        check(tag, "inv_index", int'(inv_index), exp_inv);
        check(tag, "incr_strobes", strobes, exp_strobes);
        check(tag, "load_strobes", loads, 1);
        check(tag, "busy_gaps", bad_busy, 0);
        bad_hold = 0;
        for (int c = 0; c < hold_cycles; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!done || busy || load_input || int'(sorted) != exp_sorted) bad_hold++;
        end
        if (hold_cycles > 0) check(tag, "hold_result", bad_hold, 0);
        go = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(tag, "idle_after", int'({done, busy, load_input, load_index}), 0);
    endtask

    initial begin
        int es, ee, est, base, len;
        logic [5:0] saved_idx;

        tbl[0] = '{vals: '{1, 3, 5, 7, 0, 0, 0, 0}, base: 2, len: 4, exp_sorted: 1, exp_edge: 6, exp_strobes: 3};
        tbl[1] = '{vals: '{1, 5, 3, 7, 0, 0, 0, 0}, base: 0, len: 4, exp_sorted: 0, exp_edge: 4, exp_strobes: 1};
        tbl[2] = '{vals: '{0, 0, 0, 0, 0, 0, 0, 0}, base: 3, len: 0, exp_sorted: 1, exp_edge: 3, exp_strobes: 0};
        tbl[3] = '{vals: '{9, 0, 0, 0, 0, 0, 0, 0}, base: 1, len: 1, exp_sorted: 1, exp_edge: 3, exp_strobes: 0};
        tbl[4] = '{vals: '{2, 2, 2, 0, 0, 0, 0, 0}, base: 5, len: 3, exp_sorted: 1, exp_edge: 5, exp_strobes: 2};
        tbl[5] = '{vals: '{9, 1, 0, 0, 0, 0, 0, 0}, base: 0, len: 2, exp_sorted: 0, exp_edge: 3, exp_strobes: 0};
        tbl[6] = '{vals: '{1, 2, 3, 4, 5, 6, 7, 0}, base: 7, len: 8, exp_sorted: 0, exp_edge: 9, exp_strobes: 6};
        tbl[7] = '{vals: '{5, 1, 0, 0, 0, 0, 0, 0}, base: 4, len: 1, exp_sorted: 1, exp_edge: 3, exp_strobes: 0};

        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        reset    = 1'b1;
        go       = 1'b0;
        cfg_base = 6'd0;
        cfg_len  = 6'd0;
        #1;
        check("reset", "outputs",
              int'({load_input, load_index, select_index, busy, done, sorted, inv_index}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) vals[i] = tbl[t].vals[i];
            run_case($sformatf("tbl%0d", t), tbl[t].base, tbl[t].len,
                     tbl[t].exp_sorted, tbl[t].exp_edge, tbl[t].exp_strobes, 0);
        end

        // go held through DONE_SORTED, then a fresh run must start with LOAD
        vals[0] = 1; vals[1] = 3; vals[2] = 5; vals[3] = 7;
        run_case("hold", 2, 4, 1, 6, 3, 5);
        vals[0] = 1; vals[1] = 5; vals[2] = 3; vals[3] = 7;
        run_case("restart", 0, 4, 0, 4, 1, 0);

        // Reset pulsed in the middle of a length-8 check
        for (int i = 0; i < 8; i++) vals[i] = i + 1;
        for (int i = 0; i < 8; i++) mem[10 + i] = 8'(vals[i]);
        cfg_base = 6'd10;
        cfg_len  = 6'd8;
        go       = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            if (e == 1) begin
                @(negedge clk);
                go = 1'b0;
            end
        end
        #2;
        check("midreset", "busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("midreset", "outputs_async",
              int'({load_input, load_index, select_index, busy, done, sorted, inv_index}), 0);
        saved_idx = dp_idx;
        @(posedge clk);
        @(negedge clk);
        check("midreset", "index_untouched", int'(dp_idx), int'(saved_idx));
        check("midreset", "outputs_held",
              int'({load_input, load_index, select_index, busy, done, sorted, inv_index}), 0);
        reset = 1'b0;
        model(8, es, ee, est);
        run_case("after_reset", 10, 8, es, ee, est, 0);

        // Randomized arrays against the reference model
        for (int r = 0; r < 24; r++) begin
            len  = $urandom_range(0, 12);
            base = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                vals[0] = $urandom_range(0, 10);
                for (int i = 1; i < len; i++) vals[i] = vals[i-1] + $urandom_range(0, 3);
            end else begin
                for (int i = 0; i < len; i++) vals[i] = $urandom_range(0, 15);
            end
            model(len, es, ee, est);
            run_case($sformatf("rand%0d", r), base, len, es, ee, est, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/array_sort_check_ctrl.md
ARRAY_SORT_CHECK_CTRL -- requirements
Module: array_sort_check_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- go  input  1  start request, level, held by requester
- inversion_found  input  1  datapath: element[index] > element[index+1]
- end_of_array  input  1  datapath: index >= length-1, or length==0
- load_input  output  1  datapath: capture array base and length
- load_index  output  1  datapath: write index register
- select_index  output  1  datapath: 0=clear index, 1=increment index
- busy  output  1  check in progress (LOAD or CHECK)
- done  output  1  result valid (DONE_SORTED or DONE_UNSORTED)
- sorted  output  1  1=no inversion found; valid only while done=1
- inv_index  output  5  index of first inversion; see REQ-017

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, CHECK, DONE_SORTED and DONE_UNSORTED.
REQ-004 Transitions SHALL be:
- IDLE -> LOAD when go=1, else stay
- LOAD -> CHECK unconditionally
- CHECK as REQ-005
- DONE_* -> IDLE when go=0, else stay
REQ-005 In CHECK, the following SHALL apply in priority order:
- end_of_array=1 -> DONE_SORTED
- else inversion_found=1 -> DONE_UNSORTED
- else stay in CHECK
REQ-006 LOAD SHALL assert load_input=1, load_index=1 and select_index=0; all three SHALL be 0 in every other state except as REQ-007.
REQ-007 CHECK with end_of_array=0 and inversion_found=0 SHALL assert load_index=1 and select_index=1 combinationally, in the same cycle.
REQ-008 busy SHALL be 1 exactly in LOAD and CHECK; done SHALL be 1 exactly in DONE_*; sorted SHALL be 1 only in DONE_SORTED.
REQ-009 Latency, counting from the edge sampling go=1:
- Sorted array of length L>=1: done=1 after 2+L edges.
- L=0 or L=1: done=1 after 3 edges.
- First inversion at index k: done=1 after 3+k edges.
REQ-010 end_of_array SHALL win over inversion_found in the same cycle, because the pair beyond the array end is invalid.
REQ-011 A go pulse lasting one cycle SHALL start a check; go=1 held in DONE_* SHALL hold the result, with no restart until go has returned to 0.
REQ-012 go changes during LOAD or CHECK SHALL be ignored.

Reset
REQ-013 Assertion of reset SHALL immediately force IDLE and drive load_input, load_index, select_index, busy, done, sorted=0 and inv_index=0.
REQ-014 Reset asserted mid-CHECK SHALL abort without any datapath load strobe, and SHALL leave the datapath registers untouched by the controller.
REQ-015 After reset deasserts with go=1, the block SHALL enter LOAD on the first rising edge.

Configuration
REQ-016 Macro ARRAY_SORT_CHECK_INV_INDEX_EN SHALL control the inv_index tracking feature.
REQ-017 With ARRAY_SORT_CHECK_INV_INDEX_EN defined, inv_index SHALL work as follows:
- A 5-bit shadow counter clears in LOAD.
- It increments on each cycle with load_index=1 and select_index=1, wrapping 31->0.
- It freezes in DONE_*, so that in DONE_UNSORTED it equals k.
- It holds its value until the next LOAD.
REQ-018 Without ARRAY_SORT_CHECK_INV_INDEX_EN, the inv_index port SHALL remain present and be tied to 0, with no counter logic.

Structure
REQ-019 Package array_sort_check_pkg SHALL hold the FSM state typedef (3-bit encoding) and the INDEX_W=5 constant, shared with the datapath integration.
REQ-020 No sub-module SHALL be used: the FSM and the optional counter reside in array_sort_check_ctrl; the datapath is instantiated by the integrating top, not by this block.

Verification
REQ-021 The bench SHALL pair the block with the datapath model and cover these scenarios:
- Memory [1,3,5,7] at base 2, length 4, go 1 cycle -> done=1, sorted=1 on edge 6; load_index/select_index increment strobes seen 3 times.
- Memory [1,5,3,7], length 4 -> done=1, sorted=0, inv_index=1 on edge 4.
- length 0 and length 1 -> done=1, sorted=1 on edge 3; no increment strobes.
- Reset pulsed during CHECK of length 8 -> all outputs 0 asynchronously; IDLE; a later go yields a correct full run.
- go held high through DONE_SORTED for 5 cycles -> done stays 1; go=0 -> IDLE next edge; a new go restarts with a LOAD strobe.
- Both macro builds -> inv_index=0 constantly without ARRAY_SORT_CHECK_INV_INDEX_EN; all other outputs identical between builds.
